// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - LCE/CCE/memory packet types and responder FSM states
package bp_common_pkg;

  localparam int bp_paddr_width_lp        = 40;
  localparam int bp_lce_id_width_lp       = 4;
  localparam int bp_icache_assoc_lp       = 8;
  localparam int bp_way_id_width_lp       = (bp_icache_assoc_lp > 1) ? $clog2(bp_icache_assoc_lp) : 1;
  localparam int bp_block_width_lp        = 512;
  localparam int bp_dword_width_lp        = 64;
  localparam int bp_block_offset_width_lp = $clog2(bp_block_width_lp / 8);
  localparam int bp_dword_offset_width_lp = $clog2(bp_dword_width_lp / 8);

  typedef enum logic {
    e_lce_req_miss  = 1'b0,
    e_lce_req_uc_rd = 1'b1
  } bp_lce_req_type_e;

  typedef enum logic {
    e_lce_resp_sync_ack = 1'b0,
    e_lce_resp_coh_ack  = 1'b1
  } bp_lce_resp_type_e;

  typedef enum logic [1:0] {
    e_lce_cmd_sync    = 2'd0,
    e_lce_cmd_data    = 2'd1,
    e_lce_cmd_uc_data = 2'd2
  } bp_lce_cmd_type_e;

  // Memory transfer size encoded as log2(bytes)
  typedef enum logic [2:0] {
    e_mem_size_8  = 3'd3,
    e_mem_size_64 = 3'd6
  } bp_mem_size_e;

  typedef struct packed {
    logic [bp_lce_id_width_lp-1:0] lce_id;
    bp_lce_req_type_e              req_type;
    logic [bp_way_id_width_lp-1:0] way_id;
    logic [bp_paddr_width_lp-1:0]  addr;
  } bp_lce_req_s;

  typedef struct packed {
    logic [bp_lce_id_width_lp-1:0] lce_id;
    bp_lce_resp_type_e             resp_type;
    logic [bp_paddr_width_lp-1:0]  addr;
  } bp_lce_resp_s;

  typedef struct packed {
    logic [bp_lce_id_width_lp-1:0] dst_id;
    bp_lce_cmd_type_e              cmd_type;
    logic [bp_way_id_width_lp-1:0] way_id;
    logic [bp_paddr_width_lp-1:0]  addr;
    logic [bp_block_width_lp-1:0]  data;
  } bp_lce_cmd_s;

  typedef struct packed {
    logic                         uncached;
    bp_mem_size_e                 size;
    logic [bp_paddr_width_lp-1:0] addr;
  } bp_mem_cmd_s;

  localparam int lce_req_width_lp  = $bits(bp_lce_req_s);
  localparam int lce_resp_width_lp = $bits(bp_lce_resp_s);
  localparam int lce_cmd_width_lp  = $bits(bp_lce_cmd_s);
  localparam int mem_cmd_width_lp  = $bits(bp_mem_cmd_s);

  typedef enum logic [2:0] {
    e_sync_send = 3'd0,
    e_sync_ack  = 3'd1,
    e_ready     = 3'd2,
    e_mem_cmd   = 3'd3,
    e_mem_resp  = 3'd4,
    e_lce_cmd   = 3'd5,
    e_coh_ack   = 3'd6
  } bp_fe_cce_state_e;

  function automatic logic [bp_paddr_width_lp-1:0] block_align(input logic [bp_paddr_width_lp-1:0] addr);
    return {addr[bp_paddr_width_lp-1:bp_block_offset_width_lp], {bp_block_offset_width_lp{1'b0}}};
  endfunction

  function automatic logic [bp_paddr_width_lp-1:0] dword_align(input logic [bp_paddr_width_lp-1:0] addr);
    return {addr[bp_paddr_width_lp-1:bp_dword_offset_width_lp], {bp_dword_offset_width_lp{1'b0}}};
  endfunction

  function automatic logic same_block(input logic [bp_paddr_width_lp-1:0] a,
                                      input logic [bp_paddr_width_lp-1:0] b);
    return a[bp_paddr_width_lp-1:bp_block_offset_width_lp] == b[bp_paddr_width_lp-1:bp_block_offset_width_lp];
  endfunction

endpackage

// File: rtl/bp_fe_cce_pkt_builder.sv
// rtl/bp_fe_cce_pkt_builder.sv - formats LCE and memory commands from the latched request
module bp_fe_cce_pkt_builder
  import bp_common_pkg::*;
  #(parameter int block_width_p = 512,
    parameter int dword_width_p = 64)
  (input  logic                          sync,
   input  logic [bp_lce_id_width_lp-1:0] lce_id,
   input  bp_lce_req_s                   req,
   input  logic [block_width_p-1:0]      data,
   output bp_lce_cmd_s                   lce_cmd,
   output bp_mem_cmd_s                   mem_cmd);

  localparam logic [block_width_p-1:0] dword_mask_lp =
    {{(block_width_p-dword_width_p){1'b0}}, {dword_width_p{1'b1}}};

  // LCE command: sync carries only the destination, data commands echo way/addr
  always_comb begin
    lce_cmd        = '0;
    lce_cmd.dst_id = lce_id;
    if (sync) begin
      lce_cmd.cmd_type = e_lce_cmd_sync;
    end else begin
      lce_cmd.way_id = req.way_id;
      lce_cmd.addr   = req.addr;
      if (req.req_type == e_lce_req_miss) begin
        lce_cmd.cmd_type = e_lce_cmd_data;
        lce_cmd.data     = data;
      end else begin
        lce_cmd.cmd_type = e_lce_cmd_uc_data;
        lce_cmd.data     = data & dword_mask_lp;
      end
    end
  end

  // Memory command: misses fetch a whole block, uncached reads a single dword
  always_comb begin
    mem_cmd = '0;
    if (req.req_type == e_lce_req_miss) begin
      mem_cmd.uncached = 1'b0;
      mem_cmd.size     = e_mem_size_64;
      mem_cmd.addr     = block_align(req.addr);
    end else begin
      mem_cmd.uncached = 1'b1;
      mem_cmd.size     = e_mem_size_8;
      mem_cmd.addr     = dword_align(req.addr);
    end
  end

endmodule

// File: rtl/bp_fe_cce_responder.sv
// rtl/bp_fe_cce_responder.sv - single-LCE directory-less CCE responder for the I-cache
module bp_fe_cce_responder
  import bp_common_pkg::*;
  #(parameter int paddr_width_p        = 40,
    parameter int lce_id_width_p       = 4,
    parameter int icache_assoc_p       = 8,
    parameter int icache_block_width_p = 512,
    parameter int dword_width_p        = 64,
    localparam int way_w_lp     = (icache_assoc_p > 1) ? $clog2(icache_assoc_p) : 1,
    localparam int req_w_lp     = lce_id_width_p + 1 + way_w_lp + paddr_width_p,
    localparam int resp_w_lp    = lce_id_width_p + 1 + paddr_width_p,
    localparam int cmd_w_lp     = lce_id_width_p + 2 + way_w_lp + paddr_width_p + icache_block_width_p,
    localparam int mem_cmd_w_lp = 1 + 3 + paddr_width_p)
  (input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [lce_id_width_p-1:0]       lce_id_i,
   input  logic [req_w_lp-1:0]             lce_req_i,
   input  logic                            lce_req_v_i,
   output logic                            lce_req_yumi_o,
   input  logic [resp_w_lp-1:0]            lce_resp_i,
   input  logic                            lce_resp_v_i,
   output logic                            lce_resp_yumi_o,
   output logic [cmd_w_lp-1:0]             lce_cmd_o,
   output logic                            lce_cmd_v_o,
   input  logic                            lce_cmd_ready_i,
   output logic [mem_cmd_w_lp-1:0]         mem_cmd_o,
   output logic                            mem_cmd_v_o,
   input  logic                            mem_cmd_ready_i,
   input  logic [icache_block_width_p-1:0] mem_resp_i,
   input  logic                            mem_resp_v_i,
   output logic                            mem_resp_yumi_o,
   output logic                            error_o);

  bp_fe_cce_state_e                state_r, state_n;
  bp_lce_req_s                     req_in, req_r;
  bp_lce_resp_s                    resp_in;
  bp_lce_cmd_s                     lce_cmd;
  bp_mem_cmd_s                     mem_cmd;
  logic [icache_block_width_p-1:0] data_r;
  logic                            error_r;

  logic cmd_v, req_yumi, resp_yumi, mem_cmd_v, mem_resp_yumi, err_set;

  assign req_in  = lce_req_i;
  assign resp_in = lce_resp_i;

  // Next-state and handshake decode; one transaction in flight at a time
  always_comb begin
    state_n       = state_r;
    cmd_v         = 1'b0;
    req_yumi      = 1'b0;
    resp_yumi     = 1'b0;
    mem_cmd_v     = 1'b0;
    mem_resp_yumi = 1'b0;
    err_set       = 1'b0;
    unique case (state_r)
      e_sync_send: begin
        cmd_v = 1'b1;
        if (lce_cmd_ready_i) state_n = e_sync_ack;
      end
      e_sync_ack: begin
        resp_yumi = lce_resp_v_i;
        if (lce_resp_v_i) begin
          if (resp_in.resp_type == e_lce_resp_sync_ack) state_n = e_ready;
          else                                          err_set = 1'b1;
        end
      end
      e_ready: begin
        req_yumi = lce_req_v_i;
        if (lce_req_v_i) begin
          state_n = e_mem_cmd;
          err_set = (req_in.lce_id != lce_id_i);
        end
      end
      e_mem_cmd: begin
        mem_cmd_v = 1'b1;
        if (mem_cmd_ready_i) state_n = e_mem_resp;
      end
      e_mem_resp: begin
        mem_resp_yumi = mem_resp_v_i;
        if (mem_resp_v_i) state_n = e_lce_cmd;
      end
      e_lce_cmd: begin
        cmd_v = 1'b1;
        if (lce_cmd_ready_i)
          state_n = (req_r.req_type == e_lce_req_miss) ? e_coh_ack : e_ready;
      end
      e_coh_ack: begin
        resp_yumi = lce_resp_v_i;
        if (lce_resp_v_i) begin
          if (resp_in.resp_type == e_lce_resp_coh_ack && same_block(resp_in.addr, req_r.addr))
            state_n = e_ready;
          else
            err_set = 1'b1;
        end
      end
      default: state_n = e_sync_send;
    endcase
  end

  // State register; reset always restarts with a fresh sync
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_sync_send;
    else         state_r <= state_n;
  end

  // Latch the accepted request and the returned memory data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_r  <= '0;
      data_r <= '0;
    end else begin
      if (req_yumi)      req_r  <= req_in;
      if (mem_resp_yumi) data_r <= mem_resp_i;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i)      error_r <= 1'b0;
    else if (err_set) error_r <= 1'b1;
  end

  bp_fe_cce_pkt_builder #(
    .block_width_p(icache_block_width_p),
    .dword_width_p(dword_width_p)
  ) pkt_builder (
    .sync   (state_r == e_sync_send),
    .lce_id (lce_id_i),
    .req    (req_r),
    .data   (data_r),
    .lce_cmd(lce_cmd),
    .mem_cmd(mem_cmd)
  );

  // Handshakes are held low while reset is asserted so nothing leaks out mid-reset
  assign lce_cmd_o       = lce_cmd;
  assign mem_cmd_o       = mem_cmd;
  assign lce_cmd_v_o     = cmd_v         & ~reset_i;
  assign lce_req_yumi_o  = req_yumi      & ~reset_i;
  assign lce_resp_yumi_o = resp_yumi     & ~reset_i;
  assign mem_cmd_v_o     = mem_cmd_v     & ~reset_i;
  assign mem_resp_yumi_o = mem_resp_yumi & ~reset_i;
  assign error_o         = error_r;

endmodule
